// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants, FSM encoding and digit-select helpers
//   Shared by seg7_to_nibble, seg_frame_encoder and the existing segment decoder.
//   Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    // True when exactly one active-low digit enable is asserted.
    function automatic logic one_digit_selected(input logic [3:0] an_n);
        return (an_n == 4'b0111) || (an_n == 4'b1011) ||
               (an_n == 4'b1101) || (an_n == 4'b1110);
    endfunction

    // Slot index of the asserted enable; only meaningful when one_digit_selected.
    function automatic logic [1:0] slot_of(input logic [3:0] an_n);
        logic [1:0] idx;
        case (an_n)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// rtl/seg7_to_nibble.sv - combinational seven-segment pattern to hex nibble map
//   seg     in  7  active-low segments {a,b,c,d,e,f,g}
//   nibble  out 4  decoded digit, 0 for unrecognised patterns
//   unknown out 1  pattern is not one of the 16 hex glyphs
import seg7_pkg::*;

module seg7_to_nibble (
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       unknown
);

    always_comb begin
        nibble  = 4'h0;
        unknown = 1'b0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_frame_encoder.sv
// rtl/seg_frame_encoder.sv - captures a multiplexed 4-digit seven-segment display into 16-bit frames
//   clk         in  1   clock
//   rst_n       in  1   asynchronous active-low reset
//   seg         in  7   active-low segment bus {a,b,c,d,e,f,g}
//   an_n        in  4   active-low digit enables, bit3 = most significant digit
//   word        out 16  captured frame, digit3 in [15:12]
//   err         out 4   per-digit unrecognised-pattern flags
//   word_valid  out 1   frame available
//   word_ready  in  1   consumer accepts frame when high with word_valid
import seg7_pkg::*;

module seg_frame_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an_n,
    output logic [15:0] word,
    output logic [3:0]  err,
    output logic        word_valid,
    input  logic        word_ready
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 1);

    logic [10:0]      prev_q;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0][3:0]  slots_q, slots_d;
    logic [3:0]       slot_err_q, slot_err_d;
    logic [3:0]       fill_q, fill_d;
    logic [0:0]       state_q, state_d;
    logic [15:0]      word_q, word_d;
    logic [3:0]       err_q, err_d;

    logic [10:0]      sample;
    logic             sample_valid;
    logic             same;
    logic             capture;
    logic [1:0]       slot_idx;
    logic [3:0]       fill_set;
    logic             accept;
    logic [3:0]       nibble;
    logic             unknown;

    seg7_to_nibble u_map (
        .seg     (seg),
        .nibble  (nibble),
        .unknown (unknown)
    );

    assign sample       = {seg, an_n};
    assign sample_valid = one_digit_selected(an_n);
    assign same         = (sample == prev_q);
    assign slot_idx     = slot_of(an_n);

    // Capture fires on the single cycle the counter steps onto STABLE_CYCLES;
    // once saturated it cannot fire again until the input changes.
    assign capture  = sample_valid && same && (cnt_q == CNT_CAP);
    assign fill_set = capture ? (4'b0001 << slot_idx) : 4'b0000;
    assign accept   = (state_q == ST_HOLD) && word_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (!sample_valid) begin
            cnt_d = 4'd0;
        end else if (!same) begin
            cnt_d = 4'd1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        slots_d    = slots_q;
        slot_err_d = slot_err_q;
        if (capture) begin
            slots_d[slot_idx]    = nibble;
            slot_err_d[slot_idx] = unknown;
        end
    end

    // A capture landing on the acceptance cycle belongs to the next frame.
    assign fill_d = accept ? fill_set : (fill_q | fill_set);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            ST_COLLECT: begin
                if (fill_q == 4'b1111) begin
                    state_d = ST_HOLD;
                    word_d  = slots_q;
                    err_d   = slot_err_q;
                end
            end
            default: begin
                if (word_ready) begin
                    state_d = ST_COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '1;
            cnt_q      <= '0;
            slots_q    <= '0;
            slot_err_q <= '0;
            fill_q     <= '0;
            state_q    <= ST_COLLECT;
            word_q     <= '0;
            err_q      <= '0;
        end else begin
            prev_q     <= sample;
            cnt_q      <= cnt_d;
            slots_q    <= slots_d;
            slot_err_q <= slot_err_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    assign word       = word_q;
    assign err        = err_q;
    assign word_valid = (state_q == ST_HOLD);

endmodule

// File: doc/seg_frame_encoder.md
SEG_FRAME_ENCODER -- requirements
Module: seg_frame_encoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg  input  7  active-low segment bus; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-005 an_n  input  4  active-low digit enables; bit3 = most significant digit.
REQ-006 word  output  16  captured frame; digit3 in [15:12], digit0 in [3:0].
REQ-007 err  output  4  per-digit flag; 1 = unrecognised pattern captured in that slot.
REQ-008 word_valid  output  1  frame available.
REQ-009 word_ready  input  1  consumer accepts the frame when high with word_valid.

Function
REQ-010 Pattern-to-nibble map SHALL be: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-011 Any other seg value SHALL encode as nibble 0 with the slot's err bit set.
REQ-012 A sample is valid only when exactly one an_n bit is low; any other an_n value SHALL clear the stability counter and capture nothing.
REQ-013 Stability counter SHALL increment while {seg, an_n} equals the previous cycle's value and the sample is valid, and SHALL restart at 1 on any change.
REQ-014 When the counter reaches STABLE_CYCLES, the selected slot SHALL be written (nibble, err bit) and marked filled exactly once; the counter saturates until the input changes.
REQ-015 Re-capture of an already filled slot before frame completion SHALL overwrite its nibble and err bit.
REQ-016 FSM states: COLLECT (slots filling) and HOLD (word_valid=1).
REQ-017 COLLECT->HOLD on the cycle after the fourth distinct slot becomes filled; word and err SHALL be registered on that transition.
REQ-018 In HOLD, word and err SHALL remain stable until word_valid && word_ready.
REQ-019 In HOLD, digit capture SHALL continue into the slot registers (not into word); fill flags persist.
REQ-020 On acceptance, all fill flags SHALL clear and the FSM SHALL return to COLLECT, except that a slot captured on the acceptance cycle SHALL count as filled for the next frame.
REQ-021 word_valid SHALL be a registered output; word_ready SHALL have no combinational path to any output.
REQ-022 Latency: word_valid rises 1 cycle after the completing capture.

Reset
REQ-023 rst_n low SHALL immediately force word=0, err=0, word_valid=0, fill flags=0, slot registers=0, stability counter=0, previous-sample register=all ones, FSM=COLLECT.
REQ-024 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending data; no frame is emitted after release until four new captures complete.

Structure
REQ-025 The 16 segment-pattern constants and the FSM state encoding SHALL live in a shared package seg7_pkg, reused by the existing segment decoder.
REQ-026 The pattern-to-nibble map SHALL be a combinational sub-module seg7_to_nibble (inputs seg; outputs nibble[3:0], unknown).
REQ-027 The top module SHALL contain the stability counter, slot registers, fill flags and FSM.

Verification
REQ-028 Drive digits 1,2,3,4 (an_n 0111,1011,1101,1110), each 6 cycles, word_ready=1 -> word=16'h1234, err=0, word_valid high 1 cycle.
REQ-029 Hold digit0 pattern 0001000 for only 3 cycles (STABLE_CYCLES=4) -> no capture; 4 cycles -> slot0=A.
REQ-030 word_ready=0 after frame 16'hBCDE, then recapture digit3 as 7 -> word stays 16'hBCDE until ready; next frame digit3=7.
REQ-031 Digit1 pattern 1111111 -> err=4'b0010, word[7:4]=0.
REQ-032 an_n=1100 or 1111 for 10 cycles -> no slot written, counter cleared.
REQ-033 rst_n low for 1 cycle after 3 captures -> word_valid stays 0 until 4 new captures.
